// File: rtl/ps2_pkg.sv
// ps2_pkg: scan-code set 2 prefix bytes and receiver FSM states shared by the PS/2 keyboard receiver.
package ps2_pkg;
    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, CHECK} ps2_state_t;
endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: 2-flop synchronizer, FILTER_LEN glitch filter and falling-edge strobe for one PS/2 line.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic resetn,
    input  logic line_in,
    output logic bit_evt
);
    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          s1;
    logic          s2;
    logic          clk_f;
    logic [CW-1:0] cnt;
    logic          flip;

    // The filtered level flips on the FILTER_LEN-th consecutive differing sample.
    assign flip = (s2 != clk_f) && (cnt == CW'(FILTER_LEN - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1      <= 1'b1;
            s2      <= 1'b1;
            clk_f   <= 1'b1;
            cnt     <= '0;
            bit_evt <= 1'b0;
        end else begin
            s1      <= line_in;
            s2      <= s1;
            clk_f   <= flip ? s2 : clk_f;
            cnt     <= (s2 == clk_f || flip) ? '0 : cnt + 1'b1;
            bit_evt <= flip && !s2;
        end
    end
endmodule

// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx: receive-only PS/2 keyboard frame decoder producing scan-code set 2 press/release strobes.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] keycode,
    output logic       key_pressed,
    output logic       key_released,
    output logic       extended,
    output logic       frame_error
);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

    ps2_state_t    state, state_n;
    logic          bit_evt;
    logic          dat_s1, dat;
    logic [2:0]    cnt, cnt_n;
    logic [7:0]    sh, sh_n;
    logic          par, par_n;
    logic          stp, stp_n;
    logic [WW-1:0] wd, wd_n;
    logic          ext_pend, ext_n;
    logic          brk_pend, brk_n;
    logic [7:0]    kc_n;
    logic          ex_n, kp_n, kr_n, fe_n;
    logic          timeout;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk     (CLOCK_50),
        .resetn  (resetn),
        .line_in (PS2_CLK),
        .bit_evt (bit_evt)
    );

    // Data only needs the synchronizer: it is sampled long after it settles.
    assign timeout = (state inside {DATA, PARITY, STOP}) && !bit_evt && (wd == WW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sh_n    = sh;
        par_n   = par;
        stp_n   = stp;
        wd_n    = (state == IDLE || bit_evt) ? '0 : wd + 1'b1;
        ext_n   = ext_pend;
        brk_n   = brk_pend;
        kc_n    = keycode;
        ex_n    = extended;
        kp_n    = 1'b0;
        kr_n    = 1'b0;
        fe_n    = 1'b0;
        case (state)
            IDLE: if (bit_evt && !dat) begin
                state_n = DATA;
                cnt_n   = '0;
            end
            DATA: if (bit_evt) begin
                sh_n    = {dat, sh[7:1]};
                cnt_n   = cnt + 1'b1;
                state_n = (cnt == 3'd7) ? PARITY : DATA;
            end
            PARITY: if (bit_evt) begin
                par_n   = dat;
                state_n = STOP;
            end
            STOP: if (bit_evt) begin
                stp_n   = dat;
                state_n = CHECK;
            end
            CHECK: begin
                state_n = IDLE;
                if (!(^{sh, par}) || !stp) begin
                    fe_n  = 1'b1;
                    ext_n = 1'b0;
                    brk_n = 1'b0;
                end else if (sh == PS2_EXT) begin
                    ext_n = 1'b1;
                end else if (sh == PS2_BREAK) begin
                    brk_n = 1'b1;
                end else begin
                    kc_n  = sh;
                    ex_n  = ext_pend;
                    kr_n  = brk_pend;
                    kp_n  = !brk_pend;
                    ext_n = 1'b0;
                    brk_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
        if (timeout) begin
            state_n = IDLE;
            fe_n    = 1'b1;
            ext_n   = 1'b0;
            brk_n   = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            dat_s1       <= 1'b1;
            dat          <= 1'b1;
            cnt          <= '0;
            sh           <= '0;
            par          <= 1'b0;
            stp          <= 1'b1;
            wd           <= '0;
            ext_pend     <= 1'b0;
            brk_pend     <= 1'b0;
            keycode      <= 8'h00;
            extended     <= 1'b0;
            key_pressed  <= 1'b0;
            key_released <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            state        <= state_n;
            dat_s1       <= PS2_DAT;
            dat          <= dat_s1;
            cnt          <= cnt_n;
            sh           <= sh_n;
            par          <= par_n;
            stp          <= stp_n;
            wd           <= wd_n;
            ext_pend     <= ext_n;
            brk_pend     <= brk_n;
            keycode      <= kc_n;
            extended     <= ex_n;
            key_pressed  <= kp_n;
            key_released <= kr_n;
            frame_error  <= fe_n;
        end
    end
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb_ps2_keyboard_rx: keyboard model driving PS/2 frames, scoreboard of expected key events, monitor on the strobes.
// Time is scaled 1:50 (PS/2 bit period 40 cycles, timeout 100 cycles) to keep the run short.
module tb_ps2_keyboard_rx;
    localparam int H  = 20;
    localparam int TO = 100;

    logic       CLOCK_50 = 1'b0;
    logic       resetn;
    logic       PS2_CLK;
    logic       PS2_DAT;
    logic [7:0] keycode;
    logic       key_pressed, key_released, extended, frame_error;

    ps2_keyboard_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TO)) dut (
        .CLOCK_50     (CLOCK_50),
        .resetn       (resetn),
        .PS2_CLK      (PS2_CLK),
        .PS2_DAT      (PS2_DAT),
        .keycode      (keycode),
        .key_pressed  (key_pressed),
        .key_released (key_released),
        .extended     (extended),
        .frame_error  (frame_error)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        int         kind;
        logic [7:0] code;
        logic       ext;
        logic [7:0] prev_code;
        logic       prev_ext;
    } ev_t;

    ev_t        q[$];
    ev_t        e;
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         last_fall = 0;
    int         fe_cyc = 0;
    logic [7:0] m_kc = 8'h00;
    logic       m_ext = 1'b0, m_ep = 1'b0, m_bp = 1'b0;
    logic [7:0] prev_kc = 8'h00;
    logic       prev_ext = 1'b0, prev_pulse = 1'b0;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    // Keyboard-level model: prefixes arm flags, any other valid byte is one key event.
    task automatic model(input logic [7:0] b, input logic ok);
        if (!ok) begin
            q.push_back('{2, m_kc, m_ext, m_kc, m_ext});
            m_ep = 1'b0;
            m_bp = 1'b0;
        end else if (b == 8'hE0) m_ep = 1'b1;
        else if (b == 8'hF0) m_bp = 1'b1;
        else begin
            q.push_back('{m_bp ? 1 : 0, b, m_ep, m_kc, m_ext});
            m_kc = b;
            m_ext = m_ep;
            m_ep = 1'b0;
            m_bp = 1'b0;
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            PS2_DAT = f[i];
            wait_cyc(H / 2);
            PS2_CLK = 1'b0;
            last_fall = cyc;
            wait_cyc(H);
            PS2_CLK = 1'b1;
            wait_cyc(H / 2);
        end
        PS2_DAT = 1'b1;
    endtask

    task automatic send(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        logic par;
        par = ~^b ^ bad_par;
        model(b, !bad_par && !bad_stop);
        send_bits({~bad_stop, par, b, 1'b0}, 11);
        wait_cyc(3 * H);
    endtask

    task automatic chk_idle(input string name);
        checks++;
        if (keycode !== 8'h00 || extended !== 1'b0 || key_pressed !== 1'b0 || key_released !== 1'b0 || frame_error !== 1'b0) begin
            errors++;
            $display("FAIL %s: got kc=%h ext=%b kp=%b kr=%b fe=%b, need all zero", name, keycode, extended, key_pressed, key_released, frame_error);
        end
    endtask

    always @(negedge CLOCK_50) begin
        if (!resetn) begin
            prev_kc <= 8'h00;
            prev_ext <= 1'b0;
            prev_pulse <= 1'b0;
        end else begin
            if (key_pressed || key_released || frame_error) begin
                if (frame_error) fe_cyc = cyc;
                checks++;
                if (prev_pulse) begin
                    errors++;
                    $display("FAIL strobe_width: strobe high on consecutive cycles at cycle %0d, need 1-cycle pulse", cyc);
                end else if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: kp=%b kr=%b fe=%b kc=%h at cycle %0d, none expected", key_pressed, key_released, frame_error, keycode, cyc);
                end else begin
                    e = q.pop_front();
                    if ({key_pressed, key_released, frame_error} != (e.kind == 0 ? 3'b100 : e.kind == 1 ? 3'b010 : 3'b001)
                        || keycode !== e.code || extended !== e.ext || prev_kc !== e.prev_code || prev_ext !== e.prev_ext) begin
                        errors++;
                        $display("FAIL event: got kp=%b kr=%b fe=%b kc=%h ext=%b (before kc=%h ext=%b), need kind=%0d kc=%h ext=%b (before kc=%h ext=%b)",
                                 key_pressed, key_released, frame_error, keycode, extended, prev_kc, prev_ext,
                                 e.kind, e.code, e.ext, e.prev_code, e.prev_ext);
                    end
                end
            end
            prev_kc <= keycode;
            prev_ext <= extended;
            prev_pulse <= key_pressed || key_released || frame_error;
        end
    end

    initial begin
        resetn = 1'b0;
        PS2_CLK = 1'b1;
        PS2_DAT = 1'b1;
        wait_cyc(5);
        @(negedge CLOCK_50);
        chk_idle("reset_state");
        wait_cyc(1);
        resetn = 1'b1;
        wait_cyc(20);

        send(8'h1C, 0, 0);
        send(8'hF0, 0, 0);
        send(8'h1C, 0, 0);
        send(8'hE0, 0, 0);
        send(8'hF0, 0, 0);
        send(8'h75, 0, 0);
        send(8'h1C, 0, 0);
        send(8'hF0, 0, 0);
        send(8'hF0, 0, 0);
        send(8'h1C, 0, 0);
        send(8'h1C, 1, 0);
        send(8'h27, 0, 0);
        send(8'hE0, 0, 0);
        send(8'h5A, 0, 1);
        send(8'h5A, 0, 0);

        // Partial frame then silence: watchdog must fire once.
        model(8'h00, 1'b0);
        send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 5);
        wait_cyc(10 * H);
        checks++;
        if (fe_cyc - last_fall < TO || fe_cyc - last_fall > TO + 20) begin
            errors++;
            $display("FAIL timeout_latency: frame_error %0d cycles after last fall, need %0d..%0d", fe_cyc - last_fall, TO, TO + 20);
        end
        send(8'h1C, 0, 0);

        // Reset in the middle of a frame.
        send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 4);
        resetn = 1'b0;
        m_kc = 8'h00;
        m_ext = 1'b0;
        m_ep = 1'b0;
        m_bp = 1'b0;
        wait_cyc(5);
        @(negedge CLOCK_50);
        chk_idle("midframe_reset");
        wait_cyc(1);
        resetn = 1'b1;
        wait_cyc(3 * H);
        send(8'h1C, 0, 0);

        // Single-cycle clock glitch with data low must not start a frame.
        PS2_DAT = 1'b0;
        wait_cyc(2);
        PS2_CLK = 1'b0;
        wait_cyc(1);
        PS2_CLK = 1'b1;
        wait_cyc(2);
        PS2_DAT = 1'b1;
        wait_cyc(3 * H);
        send(8'h1C, 0, 0);

        for (int i = 0; i < 40; i++) begin
            int r;
            r = $urandom_range(0, 9);
            case (r)
                0, 1: send(8'hE0, 0, 0);
                2, 3: send(8'hF0, 0, 0);
                4: send(8'($urandom_range(0, 255)), 1, 0);
                5: send(8'($urandom_range(0, 255)), 0, 1);
                default: send(8'($urandom_range(0, 255)), 0, 0);
            endcase
        end

        wait_cyc(5 * H);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected events never seen, need 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
